// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake feeding the program loader.
//   s_byte_valid : producer has a byte this cycle
//   s_byte_data  : the byte (little-endian order within words)
//   s_byte_ready : loader accepts the byte this cycle
// Modports: master = byte producer (UART/host), slave = imem_loader.
interface imem_loader_if;
  logic       s_byte_valid;
  logic [7:0] s_byte_data;
  logic       s_byte_ready;

  modport master (output s_byte_valid, output s_byte_data, input s_byte_ready);
  modport slave  (input s_byte_valid, input s_byte_data, output s_byte_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte-stream program loader for the core's
// instruction memory. Frame = 4-byte word count N (LSB first), then N words
// (LSB first), then a 4-byte checksum word when LOADER_CHECKSUM_EN is defined
// (sum of data words mod 2^32). The core is held in reset except in DONE.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             single-cycle pulse that begins a load (IDLE/DONE/ERR)
//   s_byte            byte stream (imem_loader_if.slave)
//   imem_we/addr/wdata registered single-port imem write
//   core_hold         1 = core held in reset
//   busy/done/error   load in progress / last load ok / last load aborted
//   words_loaded      data words written in the current or last load
// Optional feature macro: LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned ADDR_W     = $clog2(IMEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      s_byte,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]      state;
  logic [1:0]      byte_cnt;
  logic [23:0]     byte_buf;   // bytes 0..2 of the word being assembled
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] wl_next;
  logic [31:0]     word_in;
  logic            accept;
  logic            last_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     acc;
`endif

  assign busy      = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign core_hold = (state != S_DONE);

  assign s_byte.s_byte_ready = busy;
  assign accept    = s_byte.s_byte_valid && busy;
  assign last_byte = accept && (byte_cnt == 2'd3);
  // The 4th byte is combined directly so the word is usable on its handshake edge.
  assign word_in   = {s_byte.s_byte_data, byte_buf};
  assign wl_next   = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      byte_buf     <= '0;
      len_q        <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
`ifdef LOADER_CHECKSUM_EN
      acc          <= '0;
`endif
    end else begin
      imem_we <= 1'b0;

      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    byte_buf[7:0]   <= s_byte.s_byte_data;
          2'd1:    byte_buf[15:8]  <= s_byte.s_byte_data;
          2'd2:    byte_buf[23:16] <= s_byte.s_byte_data;
          default: ;
        endcase
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN;
            byte_cnt     <= '0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc          <= '0;
`endif
          end
        end
        S_LEN: begin
          if (last_byte) begin
            if (word_in > IMEM_WORDS) begin
              state <= S_ERR;
            end else if (word_in == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_DONE;
`endif
            end else begin
              len_q <= word_in[ADDR_W:0];
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (last_byte) begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= word_in;
            words_loaded <= wl_next;
`ifdef LOADER_CHECKSUM_EN
            acc          <= acc + word_in;
`endif
            if (wl_next == len_q) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_DONE;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (last_byte) state <= (word_in == acc) ? S_DONE : S_ERR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int unsigned IMEM_WORDS = 16;
  localparam int unsigned ADDR_W     = $clog2(IMEM_WORDS);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold, busy, done, error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader_if bus ();

  imem_loader #(.IMEM_WORDS(IMEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .s_byte(bus.slave),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]        fb[$];     // frame bytes to send
  logic [31:0]       fw[$];     // data words of the frame
  logic [31:0]       frame_csum;
  logic [ADDR_W-1:0] wa[$];     // observed write addresses
  logic [31:0]       wd[$];     // observed write data

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  function automatic logic [31:0] sum_words();
    logic [31:0] s = '0;
    foreach (fw[i]) s = s + fw[i];
    return s;
  endfunction

  task automatic build_frame(input logic [31:0] n);
    fb.delete();
    for (int b = 0; b < 4; b++) fb.push_back(n[8*b +: 8]);
    foreach (fw[i]) for (int b = 0; b < 4; b++) fb.push_back(fw[i][8*b +: 8]);
`ifdef LOADER_CHECKSUM_EN
    for (int b = 0; b < 4; b++) fb.push_back(frame_csum[8*b +: 8]);
`endif
  endtask

  task automatic start_load();
    wa.delete();
    wd.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends fb with random idle gaps; start_at pulses start alongside that byte index.
  task automatic send_frame(input int unsigned max_gap, input int start_at);
    for (int i = 0; i < fb.size(); i++) begin
      int unsigned g;
      int unsigned t;
      g = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
      repeat (g) @(negedge clk);
      bus.s_byte_valid = 1'b1;
      bus.s_byte_data  = fb[i];
      start = (i == start_at);
      t = 0;
      while (bus.s_byte_ready !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout byte %0d: ready never asserted", i);
        bus.s_byte_valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(negedge clk);
      bus.s_byte_valid = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (bus.s_byte_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", bus.s_byte_ready); end
    vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", imem_we); end
    vectors++; if ({busy, done, error} !== 3'b000) begin miscompares++; $display("FAIL reset_status got %b want 000", {busy, done, error}); end
    vectors++; if (core_hold !== 1'b1) begin miscompares++; $display("FAIL reset_hold got %b want 1", core_hold); end
    vectors++; if (imem_addr !== '0 || imem_wdata !== '0 || words_loaded !== '0) begin
      miscompares++; $display("FAIL reset_regs got addr %h data %h wl %0d want 0", imem_addr, imem_wdata, words_loaded); end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (core_hold !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_hold got hold %b busy %b want 1 0", core_hold, busy); end
  endtask

  task automatic test_basic(input int unsigned max_gap, input string tag);
    fw.delete(); fw.push_back(32'h00500293); fw.push_back(32'h00A00313);
    frame_csum = sum_words();
    build_frame(32'd2);
    start_load();
    vectors++; if (bus.s_byte_ready !== 1'b1) begin miscompares++; $display("FAIL %s start_latency ready got %b want 1", tag, bus.s_byte_ready); end
    send_frame(max_gap, -1);
`ifdef LOADER_CHECKSUM_EN
    vectors++; if (done !== 1'b1 || imem_we !== 1'b0) begin miscompares++; $display("FAIL %s csum_final done %b we %b want 1 0", tag, done, imem_we); end
`else
    vectors++; if (imem_we !== 1'b1 || done !== 1'b1 || core_hold !== 1'b0) begin
      miscompares++; $display("FAIL %s last_write_coincide we %b done %b hold %b want 1 1 0", tag, imem_we, done, core_hold); end
`endif
    repeat (3) @(negedge clk);
    vectors++; if (done !== 1'b1 || error !== 1'b0 || core_hold !== 1'b0) begin
      miscompares++; $display("FAIL %s status done %b err %b hold %b want 1 0 0", tag, done, error, core_hold); end
    vectors++; if (words_loaded !== 2) begin miscompares++; $display("FAIL %s words_loaded got %0d want 2", tag, words_loaded); end
    vectors++; if (wa.size() != 2) begin miscompares++; $display("FAIL %s write_count got %0d want 2", tag, wa.size()); end
    for (int i = 0; i < wa.size() && i < 2; i++) begin
      vectors++; if (wa[i] !== ADDR_W'(i) || wd[i] !== fw[i]) begin
        miscompares++; $display("FAIL %s write%0d got %0d:%h want %0d:%h", tag, i, wa[i], wd[i], i, fw[i]); end
    end
  endtask

  task automatic test_oversize();
    fw.delete();
    build_frame(IMEM_WORDS + 1);
    while (fb.size() > 4) void'(fb.pop_back());
    start_load();
    send_frame(0, -1);
    vectors++; if (error !== 1'b1 || bus.s_byte_ready !== 1'b0 || core_hold !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL oversize_status err %b ready %b hold %b busy %b want 1 0 1 0", error, bus.s_byte_ready, core_hold, busy); end
    bus.s_byte_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.s_byte_data = 8'($urandom);
      @(negedge clk);
    end
    bus.s_byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (wa.size() != 0 || words_loaded !== '0) begin
      miscompares++; $display("FAIL oversize_writes got %0d writes wl %0d want 0 0", wa.size(), words_loaded); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL oversize_sticky err got %b want 1", error); end
  endtask

  task automatic test_full_depth();
    fw.delete();
    for (int i = 0; i < IMEM_WORDS; i++) fw.push_back($urandom);
    frame_csum = sum_words();
    build_frame(IMEM_WORDS);
    start_load();
    send_frame(0, -1);
    repeat (3) @(negedge clk);
    vectors++; if (done !== 1'b1 || words_loaded !== (ADDR_W+1)'(IMEM_WORDS)) begin
      miscompares++; $display("FAIL full_status done %b wl %0d want 1 %0d", done, words_loaded, IMEM_WORDS); end
    vectors++; if (wa.size() != IMEM_WORDS) begin miscompares++; $display("FAIL full_count got %0d want %0d", wa.size(), IMEM_WORDS); end
    for (int i = 0; i < wa.size() && i < IMEM_WORDS; i++) begin
      vectors++; if (wa[i] !== ADDR_W'(i) || wd[i] !== fw[i]) begin
        miscompares++; $display("FAIL full_write%0d got %0d:%h want %0d:%h", i, wa[i], wd[i], i, fw[i]); end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      fw.delete();
      repeat (3) fw.push_back(32'h00000013);
      frame_csum = (pass == 0) ? 32'h00000039 : 32'h0000003A;
      build_frame(32'd3);
      start_load();
      send_frame(0, -1);
      repeat (2) @(negedge clk);
      vectors++; if (done !== (pass == 0) || error !== (pass == 1) || core_hold !== (pass == 1)) begin
        miscompares++; $display("FAIL csum%0d status done %b err %b hold %b", pass, done, error, core_hold); end
      vectors++; if (wa.size() != 3) begin miscompares++; $display("FAIL csum%0d write_count got %0d want 3", pass, wa.size()); end
    end
  endtask
`endif

  task automatic test_reset_midload();
    fw.delete();
    for (int i = 0; i < 4; i++) fw.push_back($urandom);
    frame_csum = sum_words();
    build_frame(32'd4);
    while (fb.size() > 6) void'(fb.pop_back());
    start_load();
    send_frame(0, -1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (busy !== 1'b0 || bus.s_byte_ready !== 1'b0 || core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      miscompares++; $display("FAIL midreset_idle busy %b ready %b hold %b done %b err %b want 0 0 1 0 0",
                              busy, bus.s_byte_ready, core_hold, done, error); end
    repeat (5) @(negedge clk);
    vectors++; if (wa.size() != 0) begin miscompares++; $display("FAIL midreset_writes got %0d want 0", wa.size()); end
    test_basic(0, "after_reset");
  endtask

  task automatic test_zero_and_start_ignored();
    fw.delete();
    frame_csum = '0;
    build_frame(32'd0);
    start_load();
    send_frame(0, -1);
    repeat (2) @(negedge clk);
    vectors++; if (done !== 1'b1 || core_hold !== 1'b0 || wa.size() != 0 || words_loaded !== '0) begin
      miscompares++; $display("FAIL zero_len done %b hold %b writes %0d wl %0d want 1 0 0 0", done, core_hold, wa.size(), words_loaded); end
    fw.delete();
    for (int i = 0; i < 3; i++) fw.push_back($urandom);
    frame_csum = sum_words();
    build_frame(32'd3);
    start_load();
    send_frame(1, 9);   // start pulsed alongside a DATA byte
    repeat (3) @(negedge clk);
    vectors++; if (done !== 1'b1 || words_loaded !== 3 || wa.size() != 3) begin
      miscompares++; $display("FAIL start_in_data done %b wl %0d writes %0d want 1 3 3", done, words_loaded, wa.size()); end
    for (int i = 0; i < wa.size() && i < 3; i++) begin
      vectors++; if (wa[i] !== ADDR_W'(i) || wd[i] !== fw[i]) begin
        miscompares++; $display("FAIL start_in_data_w%0d got %0d:%h want %0d:%h", i, wa[i], wd[i], i, fw[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int unsigned n;
      bit exp_ok;
      n = $urandom_range(8, 1);
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back($urandom);
      frame_csum = sum_words();
      exp_ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(1, 0) == 1) begin
        frame_csum = frame_csum ^ (32'h1 << $urandom_range(31, 0));
        exp_ok = 1'b0;
      end
`endif
      build_frame(n);
      start_load();
      send_frame(5, -1);
      repeat (3) @(negedge clk);
      vectors++; if (done !== exp_ok || error !== !exp_ok || core_hold !== !exp_ok) begin
        miscompares++; $display("FAIL rand%0d status done %b err %b hold %b want ok=%b", it, done, error, core_hold, exp_ok); end
      vectors++; if (words_loaded !== (ADDR_W+1)'(n) || wa.size() != n) begin
        miscompares++; $display("FAIL rand%0d count wl %0d writes %0d want %0d", it, words_loaded, wa.size(), n); end
      for (int i = 0; i < wa.size() && i < n; i++) begin
        vectors++; if (wa[i] !== ADDR_W'(i) || wd[i] !== fw[i]) begin
          miscompares++; $display("FAIL rand%0d_w%0d got %0d:%h want %0d:%h", it, i, wa[i], wd[i], i, fw[i]); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.s_byte_valid = 1'b0;
    bus.s_byte_data  = '0;
    @(negedge clk);
    test_reset();
    test_basic(0, "basic");
    test_basic(5, "gapped");
    test_oversize();
    test_full_depth();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    test_zero_and_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
